// File: rtl/if_pc_gen_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM encoding and the slot-selection helper.
package if_pc_gen_pkg;

  localparam int          InstBus      = 32;
  localparam int          FetchBus     = 64;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        Stop         = 1'b1;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [1:0]         valid;
    logic [InstBus-1:0] inst0;
    logic [InstBus-1:0] inst1;
  } fetch_slots_t;

  // An odd-word pc only owns the upper half of the fetched doubleword.
  function automatic fetch_slots_t pick_slots(input logic odd,
                                              input logic [FetchBus-1:0] data);
    fetch_slots_t s;
    if (odd) begin
      s.valid = 2'b01;
      s.inst0 = data[63:32];
      s.inst1 = ZeroWord;
    end else begin
      s.valid = 2'b11;
      s.inst0 = data[31:0];
      s.inst1 = data[63:32];
    end
    return s;
  endfunction

endpackage

// File: rtl/if_pc_gen_if.sv
// Instruction-memory fetch bus: valid/ready request channel, valid-only response.
interface if_pc_gen_if import if_pc_gen_pkg::*; #(parameter int ADDR_W = 32) ();

  logic                ireq_valid;
  logic [ADDR_W-1:0]   ireq_addr;
  logic                ireq_ready;
  logic                irsp_valid;
  logic [FetchBus-1:0] irsp_data;

  modport master (output ireq_valid, ireq_addr,
                  input  ireq_ready, irsp_valid, irsp_data);
  modport slave  (input  ireq_valid, ireq_addr,
                  output ireq_ready, irsp_valid, irsp_data);

endinterface

// File: rtl/if_pc_gen_redirect_mux.sv
// Next-pc priority select: exception flush, then taken branch, then sequential.
module if_redirect_mux #(
  parameter int ADDR_W = 32
) (
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              redirect_o
);

  assign redirect_o = flush_i | branch_flag_i;

  // Sequential step re-aligns to the doubleword, so +4 and +8 share one adder.
  always_comb begin
    if (flush_i)            pc_next_o = new_pc_i;
    else if (branch_flag_i) pc_next_o = branch_target_i;
    else if (advance_i)     pc_next_o = {pc_i[ADDR_W-1:3], 3'b000} + ADDR_W'(8);
    else                    pc_next_o = pc_i;
  end

endmodule

// File: rtl/if_pc_gen.sv
// PC generation and fetch FSM; issues doubleword fetches and builds the
// two-slot fetch packet for the IF/ID register.
module if_pc_gen import if_pc_gen_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   new_pc_i,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_i,
  if_pc_gen_if.master         imem,
  output logic [1:0]          pkt_valid_o,
  output logic [ADDR_W-1:0]   pkt_pc_o,
  output logic [InstBus-1:0]  pkt_inst0_o,
  output logic [InstBus-1:0]  pkt_inst1_o
);

  if_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                discard_q, discard_d;
  logic [FetchBus-1:0] hold_q, hold_d;
  logic [1:0]          pkt_valid_q, pkt_valid_d;
  logic [ADDR_W-1:0]   pkt_pc_q, pkt_pc_d;
  logic [InstBus-1:0]  pkt_inst0_q, pkt_inst0_d;
  logic [InstBus-1:0]  pkt_inst1_q, pkt_inst1_d;

  logic                fire, redirect, load, stalled;
  logic [FetchBus-1:0] load_data;
  fetch_slots_t        slots;

  assign stalled         = (stall_i == Stop);
  assign imem.ireq_valid = rst_n && (state_q == IF_REQ);
  assign imem.ireq_addr  = {pc_q[ADDR_W-1:3], 3'b000};
  assign fire            = imem.ireq_valid & imem.ireq_ready;

  if_redirect_mux #(.ADDR_W(ADDR_W)) u_redirect_mux (
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_i            (pc_q),
    .advance_i       (load),
    .pc_next_o       (pc_d),
    .redirect_o      (redirect)
  );

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_data = hold_q;
    unique case (state_q)
      IF_REQ: begin
        // A request accepted alongside a redirect fetches the stale pc.
        if (fire) begin
          state_d = IF_WAIT;
          if (redirect) discard_d = 1'b1;
        end
      end
      IF_WAIT: begin
        if (imem.irsp_valid) begin
          if (discard_q || redirect) begin
            discard_d = 1'b0;
            state_d   = IF_REQ;
          end else if (!stalled) begin
            load      = 1'b1;
            load_data = imem.irsp_data;
            state_d   = IF_REQ;
          end else begin
            hold_d  = imem.irsp_data;
            state_d = IF_HOLD;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (redirect) begin
          state_d = IF_REQ;
        end else if (!stalled) begin
          load    = 1'b1;
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_REQ;
    endcase
  end

  always_comb begin
    slots       = pick_slots(pc_q[2], load_data);
    pkt_valid_d = pkt_valid_q;
    pkt_pc_d    = pkt_pc_q;
    pkt_inst0_d = pkt_inst0_q;
    pkt_inst1_d = pkt_inst1_q;
    if (redirect) begin
      pkt_valid_d = 2'b00;
    end else if (load) begin
      pkt_valid_d = slots.valid;
      pkt_pc_d    = pc_q;
      pkt_inst0_d = slots.inst0;
      pkt_inst1_d = slots.inst1;
    end else if (!stalled) begin
      pkt_valid_d = 2'b00;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IF_REQ;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      pkt_valid_q <= 2'b00;
      pkt_pc_q    <= '0;
      pkt_inst0_q <= ZeroWord;
      pkt_inst1_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_pc_q    <= pkt_pc_d;
      pkt_inst0_q <= pkt_inst0_d;
      pkt_inst1_q <= pkt_inst1_d;
    end
  end

  // NOTE: the hold buffer is plain data, left unreset; it is only read after HOLD wrote it.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign pkt_valid_o = pkt_valid_q;
  assign pkt_pc_o    = pkt_pc_q;
  assign pkt_inst0_o = pkt_inst0_q;
  assign pkt_inst1_o = pkt_inst1_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: in-order memory model, request and packet
// scoreboards filled by the stimulus and drained as the DUT produces output.
module tb_if_pc_gen;
  import if_pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, flush_i, branch_flag_i;
  logic [31:0] new_pc_i, branch_target_i;
  logic [1:0]  pkt_valid_o;
  logic [31:0] pkt_pc_o, pkt_inst0_o, pkt_inst1_o;

  always #5 clk = ~clk;

  if_pc_gen_if #(.ADDR_W(32)) imem ();

  if_pc_gen #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem            (imem),
    .pkt_valid_o     (pkt_valid_o),
    .pkt_pc_o        (pkt_pc_o),
    .pkt_inst0_o     (pkt_inst0_o),
    .pkt_inst1_o     (pkt_inst1_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  valid;
    logic [31:0] i0;
    logic [31:0] i1;
  } exp_pkt_t;

  exp_pkt_t    pkt_q[$];
  logic [31:0] req_q[$];
  int          checks = 0;
  int          errors = 0;

  bit          pend = 1'b0;
  int          cnt  = 0;
  int          lat  = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input logic [31:0] pc);
    exp_pkt_t    e;
    logic [31:0] a;
    a    = {pc[31:3], 3'b000};
    e.pc = pc;
    if (pc[2]) begin
      e.valid = 2'b01;
      e.i0    = mem_word(a + 32'd4);
      e.i1    = 32'h0;
    end else begin
      e.valid = 2'b11;
      e.i0    = mem_word(a);
      e.i1    = mem_word(a + 32'd4);
    end
    pkt_q.push_back(e);
  endtask

  // One clock: check any request firing, advance the memory model, and
  // compare a freshly loaded packet against the scoreboard.
  task automatic tick();
    logic        fire, stall_at_edge;
    logic [31:0] a;
    exp_pkt_t    e;
    #1;
    fire          = imem.ireq_valid && imem.ireq_ready;
    a             = imem.ireq_addr;
    stall_at_edge = stall_i;
    if (fire) begin
      if (req_q.size() == 0) check("req_unexpected", 64'(fire), 64'(0));
      else                   check("req_addr", 64'(a), 64'(req_q.pop_front()));
    end
    @(posedge clk);
    #1;
    imem.irsp_valid = 1'b0;
    if (fire) begin
      pend      = 1'b1;
      cnt       = lat;
      pend_addr = a;
    end
    if (pend) begin
      if (cnt == 0) begin
        imem.irsp_valid = 1'b1;
        imem.irsp_data  = {mem_word(pend_addr + 32'd4), mem_word(pend_addr)};
        pend            = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (!stall_at_edge && pkt_valid_o != 2'b00) begin
      if (pkt_q.size() == 0) begin
        check("pkt_unexpected", 64'(pkt_valid_o), 64'(0));
      end else begin
        e = pkt_q.pop_front();
        check("pkt_pc",    64'(pkt_pc_o),    64'(e.pc));
        check("pkt_valid", 64'(pkt_valid_o), 64'(e.valid));
        check("pkt_inst0", 64'(pkt_inst0_o), 64'(e.i0));
        check("pkt_inst1", 64'(pkt_inst1_o), 64'(e.i1));
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    branch_flag_i   = 1'b0;
    new_pc_i        = '0;
    branch_target_i = '0;
    imem.ireq_ready = 1'b0;
    imem.irsp_valid = 1'b0;
    imem.irsp_data  = '0;
    tick();
    tick();
    check("reset_pkt_valid",  64'(pkt_valid_o), 64'(0));
    check("reset_pkt_pc",     64'(pkt_pc_o),    64'(0));
    check("reset_pkt_inst0",  64'(pkt_inst0_o), 64'(0));
    check("reset_pkt_inst1",  64'(pkt_inst1_o), 64'(0));
    check("reset_ireq_valid", 64'(imem.ireq_valid), 64'(0));

    // Back-to-back sequential fetch with single-cycle response latency.
    rst_n           = 1'b1;
    imem.ireq_ready = 1'b1;
    req_q.push_back(32'h0);
    req_q.push_back(32'h8);
    req_q.push_back(32'h10);
    push_pkt(32'h0);
    push_pkt(32'h8);
    repeat (4) tick();

    // Branch while waiting on 0x10; the stale response must be dropped.
    lat     = 2;
    stall_i = 1'b1;
    tick();
    check("stall_keeps_valid", 64'(pkt_valid_o), 64'(2'b11));
    check("stall_keeps_pc",    64'(pkt_pc_o),    64'(32'h8));
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h104;
    tick();
    check("branch_clears_pkt", 64'(pkt_valid_o), 64'(0));
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;
    lat           = 0;
    req_q.push_back(32'h100);
    req_q.push_back(32'h108);
    push_pkt(32'h104);
    push_pkt(32'h108);
    repeat (6) tick();

    // Stall for three cycles across a response arrival.
    req_q.push_back(32'h110);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pkt_pc",    64'(pkt_pc_o),         64'(32'h108));
      check("hold_pkt_valid", 64'(pkt_valid_o),      64'(2'b11));
      check("hold_no_req",    64'(imem.ireq_valid),  64'(0));
    end
    stall_i         = 1'b0;
    imem.ireq_ready = 1'b0;
    push_pkt(32'h110);
    tick();

    // Flush and branch together: flush wins.
    flush_i         = 1'b1;
    new_pc_i        = 32'h0C;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h200;
    tick();
    check("flush_req_addr",  64'(imem.ireq_addr),  64'(32'h08));
    check("flush_req_valid", 64'(imem.ireq_valid), 64'(1));
    flush_i         = 1'b0;
    branch_flag_i   = 1'b0;
    imem.ireq_ready = 1'b1;
    req_q.push_back(32'h08);
    push_pkt(32'h0C);
    tick();
    imem.ireq_ready = 1'b0;
    tick();

    // Memory not ready: address holds; a branch retargets the pending request.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("noready_addr",  64'(imem.ireq_addr),  64'(32'h10));
      check("noready_valid", 64'(imem.ireq_valid), 64'(1));
    end
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h300;
    tick();
    check("retarget_addr", 64'(imem.ireq_addr), 64'(32'h300));
    branch_flag_i   = 1'b0;
    imem.ireq_ready = 1'b1;
    req_q.push_back(32'h300);
    push_pkt(32'h300);
    tick();
    imem.ireq_ready = 1'b0;
    tick();

    // Wrap from the top of the address space, then reset mid-transaction.
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFF8;
    tick();
    branch_flag_i   = 1'b0;
    imem.ireq_ready = 1'b1;
    req_q.push_back(32'hFFFF_FFF8);
    req_q.push_back(32'h0);
    push_pkt(32'hFFFF_FFF8);
    tick();
    tick();
    check("wrap_addr", 64'(imem.ireq_addr), 64'(32'h0));
    lat = 3;
    tick();
    imem.ireq_ready = 1'b0;
    rst_n           = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("late_rsp_dropped", 64'(pkt_valid_o),      64'(0));
    check("reset_pc_addr",    64'(imem.ireq_addr),   64'(32'h0));
    check("reset_pc_valid",   64'(imem.ireq_valid),  64'(1));
    imem.ireq_ready = 1'b1;
    lat             = 0;
    req_q.push_back(32'h0);
    push_pkt(32'h0);
    tick();
    imem.ireq_ready = 1'b0;
    tick();

    check("req_queue_drained", 64'(req_q.size()), 64'(0));
    check("pkt_queue_drained", 64'(pkt_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
